// File: rtl/dram_controller.sv
// Single-channel DRAM controller: 8-deep L2 request FIFO, PRE/ACT/RW command handshake and
// bit-serial data transfer. Define DRAM_CTRL_ROW_HIT_EN for the open-page (row-hit) policy.
`timescale 1ns/1ps
module dram_controller #(
  parameter int L2_REQ_WIDTH   = 20,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_OF_BANKS   = 8,
  parameter int NUM_OF_ROWS    = 128,
  parameter int NUM_OF_COLS    = 8,
  parameter int CONCAT_ADDRESS = 20
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    l2_rw_req,
  input  logic [L2_REQ_WIDTH-1:0] l2_req_instr,
  input  logic [DATA_WIDTH-1:0]   l2_req_data,
  output logic [DATA_WIDTH-1:0]   l2_rsp_data,
  output logic                    cmd_req,
  input  logic                    cmd_ack,
  output logic [1:0]              cmd,
  output logic [NUM_OF_BANKS-1:0] bank_sel,
  output logic [NUM_OF_ROWS-1:0]  row_sel,
  output logic [NUM_OF_COLS-1:0]  col_sel,
  output logic                    bank_rw,
  output logic                    buf_rw,
  inout  wire                     dram_data
);
  localparam int BANK_W     = $clog2(NUM_OF_BANKS);
  localparam int ROW_W      = $clog2(NUM_OF_ROWS);
  localparam int COL_W      = $clog2(NUM_OF_COLS);
  localparam int COL_LSB    = 3;
  localparam int ROW_LSB    = COL_LSB + COL_W;
  localparam int BANK_LSB   = ROW_LSB + ROW_W;
  localparam int FIFO_DEPTH = 8;
  localparam int PTR_W      = 3;
  localparam int ENTRY_W    = 1 + CONCAT_ADDRESS + DATA_WIDTH;
  localparam int CNT_W      = $clog2(DATA_WIDTH + 1);
  localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

  localparam logic [1:0] CMD_PRE = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_RD  = 2'b11;

  typedef enum logic [2:0] {IDLE, PRE, ACT, RW, XFER} state_t;

  state_t                  state, state_n;
  logic                    ack_seen, ack_seen_n;
  logic                    pop, push, row_hit, sel_en, wr_drive, last_bit, cmd_done;
  logic [ENTRY_W-1:0]      fifo_mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]      head;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [PTR_W:0]          fifo_cnt;
  logic [L2_REQ_WIDTH-1:0] prev_instr;
  logic                    cur_rw;
  logic [CONCAT_ADDRESS-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]   xfer_sh;
  logic [CNT_W-1:0]        access_count;
  logic [BANK_W-1:0]       bank_id;
  logic [ROW_W-1:0]        row_id;
  logic [COL_W-1:0]        col_id;
  logic                    unused_addr;

  // Request capture: a new request is any change of the L2 address.
  assign push = (l2_req_instr != prev_instr) && (fifo_cnt != FULL_CNT);
  assign head = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      prev_instr <= '0;
    end else begin
      prev_instr <= l2_req_instr;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {l2_rw_req, l2_req_instr[CONCAT_ADDRESS-1:0], l2_req_data};
  end

  // Active request and serial shift register (write data out MSB first, read data in).
  always_ff @(posedge clk) begin
    if (pop)                {cur_rw, cur_addr, xfer_sh} <= head;
    else if (state == XFER) xfer_sh <= {xfer_sh[DATA_WIDTH-2:0], dram_data};
  end

  assign bank_id     = cur_addr[BANK_LSB +: BANK_W];
  assign row_id      = cur_addr[ROW_LSB +: ROW_W];
  assign col_id      = cur_addr[COL_LSB +: COL_W];
  assign unused_addr = ^cur_addr;

  assign bank_sel  = sel_en ? (NUM_OF_BANKS'(1) << bank_id) : '0;
  assign row_sel   = sel_en ? (NUM_OF_ROWS'(1) << row_id) : '0;
  assign col_sel   = sel_en ? (NUM_OF_COLS'(1) << col_id) : '0;
  assign dram_data = wr_drive ? xfer_sh[DATA_WIDTH-1] : 1'bz;

  assign last_bit = (state == XFER) && (access_count == CNT_W'(1));
  assign cmd_done = ack_seen && !cmd_ack;

`ifdef DRAM_CTRL_ROW_HIT_EN
  logic [ROW_W-1:0]        open_row [NUM_OF_BANKS];
  logic [NUM_OF_BANKS-1:0] open_vld;
  logic [BANK_W-1:0]       head_bank;
  logic [ROW_W-1:0]        head_row;

  assign head_bank = head[DATA_WIDTH + BANK_LSB +: BANK_W];
  assign head_row  = head[DATA_WIDTH + ROW_LSB +: ROW_W];
  assign row_hit   = open_vld[head_bank] && (open_row[head_bank] == head_row);

  // A row counts as open once its ACTIVATE handshake has completed.
  always_ff @(posedge clk) begin
    if (!rst_b)                         open_vld <= '0;
    else if (state == ACT && cmd_done)  open_vld[bank_id] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (state == ACT && cmd_done) open_row[bank_id] <= row_id;
  end
`else
  assign row_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state    <= IDLE;
      ack_seen <= 1'b0;
    end else begin
      state    <= state_n;
      ack_seen <= ack_seen_n;
    end
  end

  // Transfer counter and read response
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      access_count <= '0;
      l2_rsp_data  <= '0;
    end else begin
      if (state == RW && state_n == XFER) access_count <= CNT_W'(DATA_WIDTH);
      else if (state == XFER)             access_count <= access_count - 1'b1;
      if (last_bit && !cur_rw) l2_rsp_data <= {xfer_sh[DATA_WIDTH-2:0], dram_data};
    end
  end

  // Next state and outputs; each command state runs a full 4-phase handshake.
  always_comb begin
    state_n    = state;
    ack_seen_n = ack_seen;
    pop        = 1'b0;
    cmd_req    = 1'b0;
    cmd        = CMD_PRE;
    bank_rw    = 1'b0;
    buf_rw     = 1'b0;
    sel_en     = 1'b0;
    wr_drive   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_cnt != '0) begin
          pop = 1'b1;
          if (row_hit) state_n = RW;
          else         state_n = PRE;
        end
      end
      PRE, ACT, RW: begin
        sel_en  = 1'b1;
        cmd_req = !ack_seen;
        if (state == ACT) begin
          cmd = CMD_ACT;
        end else if (state == RW) begin
          cmd     = cur_rw ? CMD_WR : CMD_RD;
          bank_rw = cur_rw;
        end
        if (!ack_seen && cmd_ack) begin
          ack_seen_n = 1'b1;
        end else if (cmd_done) begin
          ack_seen_n = 1'b0;
          if (state == PRE)      state_n = ACT;
          else if (state == ACT) state_n = RW;
          else                   state_n = XFER;
        end
      end
      XFER: begin
        sel_en   = 1'b1;
        bank_rw  = cur_rw;
        buf_rw   = cur_rw;
        wr_drive = cur_rw;
        if (last_bit) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dram_controller.sv
// Randomized bench for dram_controller: bit-serial DRAM responder plus a request-level
// reference model of commands, stored bytes and read responses.
`timescale 1ns/1ps
module tb_dram_controller;
  localparam int AW = 20, DW = 8, NB = 8, NR = 128, NC = 8, FIFO_DEPTH = 8;
  localparam logic [1:0] C_PRE = 2'b00, C_ACT = 2'b01, C_WR = 2'b10, C_RD = 2'b11;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          l2_rw_req = 1'b0;
  logic [AW-1:0] l2_req_instr = '0;
  logic [DW-1:0] l2_req_data = '0;
  logic [DW-1:0] l2_rsp_data;
  logic          cmd_req;
  logic          cmd_ack = 1'b0;
  logic [1:0]    cmd;
  logic [NB-1:0] bank_sel;
  logic [NR-1:0] row_sel;
  logic [NC-1:0] col_sel;
  logic          bank_rw, buf_rw;
  wire           dram_data;
  logic          tb_drv = 1'b0, tb_bit = 1'b0;

  assign dram_data = tb_drv ? tb_bit : 1'bz;
  always #5 clk = ~clk;

  dram_controller #(.L2_REQ_WIDTH(AW), .DATA_WIDTH(DW), .NUM_OF_BANKS(NB),
                    .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .CONCAT_ADDRESS(AW)) dut (
    .clk(clk), .rst_b(rst_b), .l2_rw_req(l2_rw_req), .l2_req_instr(l2_req_instr),
    .l2_req_data(l2_req_data), .l2_rsp_data(l2_rsp_data), .cmd_req(cmd_req),
    .cmd_ack(cmd_ack), .cmd(cmd), .bank_sel(bank_sel), .row_sel(row_sel),
    .col_sel(col_sel), .bank_rw(bank_rw), .buf_rw(buf_rw), .dram_data(dram_data));

  typedef struct packed {
    logic [1:0]    c;
    logic [NB-1:0] b;
    logic [NR-1:0] r;
    logic [NC-1:0] col;
    logic          rw;
  } cmd_t;

  cmd_t          cmd_log[$], exp_cmd[$];
  logic [DW-1:0] wr_log[$], exp_wr[$], rsp_log[$], exp_rsp[$];
  logic [DW-1:0] dram_mem [NB*NR*NC];
  logic [DW-1:0] ref_mem  [NB*NR*NC];
  logic [NR-1:0] m_open_row [NB];
  logic [NB-1:0] m_open_vld = '0;
  int            hold_ack = 0;
  int            ack_extra = 0;
  int            total = 0, bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [127:0] v);
    for (int i = 0; i < 128; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference: each accepted request maps to bank/row/col and a command list.
  task automatic model_req(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int   bk, row, cl, loc;
    bit   need_open;
    cmd_t e;
    bk  = int'(a[15:13]);
    row = int'(a[12:6]);
    cl  = int'(a[5:3]);
    loc = (bk * NR + row) * NC + cl;
    need_open = 1'b1;
`ifdef DRAM_CTRL_ROW_HIT_EN
    if (m_open_vld[bk] && m_open_row[bk] == NR'(row)) need_open = 1'b0;
    m_open_vld[bk] = 1'b1;
    m_open_row[bk] = NR'(row);
`endif
    e = '0;
    e.b[bk]   = 1'b1;
    e.r[row]  = 1'b1;
    e.col[cl] = 1'b1;
    if (need_open) begin
      e.c = C_PRE; exp_cmd.push_back(e);
      e.c = C_ACT; exp_cmd.push_back(e);
    end
    e.c  = rw ? C_WR : C_RD;
    e.rw = rw;
    exp_cmd.push_back(e);
    if (rw) begin
      exp_wr.push_back(d);
      ref_mem[loc] = d;
    end else begin
      exp_rsp.push_back(ref_mem[loc]);
    end
  endtask

  // DRAM bank model: acknowledges commands, captures write bits, serves read bits.
  initial begin : responder
    cmd_t          e;
    logic [DW-1:0] byte_v;
    int            idx, n;
    forever begin
      @(negedge clk);
      if (cmd_req && hold_ack == 0) begin
        e.c = cmd; e.b = bank_sel; e.r = row_sel; e.col = col_sel; e.rw = bank_rw;
        cmd_log.push_back(e);
        idx = (onehot_idx(128'(bank_sel)) * NR + onehot_idx(row_sel)) * NC
              + onehot_idx(128'(col_sel));
        for (int k = 0; k < ack_extra; k++) begin
          @(negedge clk);
          check("req_hold", cmd_req, 1'b1);
          check("cmd_stable", cmd, e.c);
        end
        #3 cmd_ack = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (cmd_req && n < 20);
        check("req_fall_lat", n, 1);
        #3 cmd_ack = 1'b0;
        if (e.c == C_WR) begin
          for (int k = DW - 1; k >= 0; k--) begin
            @(negedge clk);
            byte_v[k] = dram_data;
            check("wr_dir", {bank_rw, buf_rw}, 2'b11);
          end
          wr_log.push_back(byte_v);
          dram_mem[idx] = byte_v;
        end else if (e.c == C_RD) begin
          byte_v = dram_mem[idx];
          for (int k = DW - 1; k >= 0; k--) begin
            @(negedge clk);
            tb_drv = 1'b1;
            tb_bit = byte_v[k];
            check("rd_dir", {bank_rw, buf_rw}, 2'b00);
          end
          @(negedge clk);
          tb_drv = 1'b0;
          rsp_log.push_back(l2_rsp_data);
        end
      end
    end
  end

  task automatic send(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit accept);
    @(negedge clk);
    l2_rw_req    = rw;
    l2_req_instr = a;
    l2_req_data  = d;
    if (accept) model_req(rw, a, d);
  endtask

  task automatic wait_quiet();
    int cyc = 0;
    while ((cmd_log.size() < exp_cmd.size() || wr_log.size() < exp_wr.size() ||
            rsp_log.size() < exp_rsp.size()) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    int n;
    check({tag, "_ncmd"}, cmd_log.size(), exp_cmd.size());
    n = (cmd_log.size() < exp_cmd.size()) ? cmd_log.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_cmd"},  cmd_log[i].c,   exp_cmd[i].c);
      check({tag, "_bank"}, cmd_log[i].b,   exp_cmd[i].b);
      check({tag, "_row"},  cmd_log[i].r,   exp_cmd[i].r);
      check({tag, "_col"},  cmd_log[i].col, exp_cmd[i].col);
      if (exp_cmd[i].c == C_WR || exp_cmd[i].c == C_RD)
        check({tag, "_bank_rw"}, cmd_log[i].rw, exp_cmd[i].rw);
    end
    check({tag, "_nwr"}, wr_log.size(), exp_wr.size());
    n = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
    for (int i = 0; i < n; i++) check({tag, "_wbyte"}, wr_log[i], exp_wr[i]);
    check({tag, "_nrd"}, rsp_log.size(), exp_rsp.size());
    n = (rsp_log.size() < exp_rsp.size()) ? rsp_log.size() : exp_rsp.size();
    for (int i = 0; i < n; i++) check({tag, "_rsp"}, rsp_log[i], exp_rsp[i]);
    check({tag, "_acnt"}, dut.access_count, 0);
    check({tag, "_idle_req"}, cmd_req, 1'b0);
    cmd_log.delete(); exp_cmd.delete();
    wr_log.delete();  exp_wr.delete();
    rsp_log.delete(); exp_rsp.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [AW-1:0] a;
    logic          rw;
    int            nreq;
    for (int i = 0; i < NB*NR*NC; i++) begin
      dram_mem[i] = '0;
      ref_mem[i]  = '0;
    end

    // Reset
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp", l2_rsp_data, '0);
    check("rst_cmd_req", cmd_req, 1'b0);
    check("rst_cmd", cmd, 2'b00);
    check("rst_sels", {bank_sel, row_sel, col_sel}, '0);
    check("rst_dir", {bank_rw, buf_rw}, 2'b00);
    check("rst_acnt", dut.access_count, 0);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // Single write, ack 8 ns after each cmd_req edge
    ack_extra = 0;
    send(1'b1, 20'h0_A5C8, 8'h3C, 1'b1);
    wait_quiet();
    if (cmd_log.size() == 3) begin
      check("dir_cmd0", cmd_log[0].c, C_PRE);
      check("dir_cmd1", cmd_log[1].c, C_ACT);
      check("dir_cmd2", cmd_log[2].c, C_WR);
      check("dir_bank", cmd_log[2].b, 8'b0010_0000);
      check("dir_row", cmd_log[2].r, 128'(1) << 23);
      check("dir_col", cmd_log[2].col, 8'b0000_0010);
    end
    if (wr_log.size() > 0) check("dir_wbyte", wr_log[0], 8'h3C);
    compare_all("dir_wr");

    // Reads of the same location via different offset and ignored upper bits
    send(1'b0, 20'h0_A5CC, 8'h00, 1'b1);
    send(1'b0, 20'h5_A5C8, 8'h00, 1'b1);
    wait_quiet();
    if (rsp_log.size() > 0) check("dir_rsp", rsp_log[0], 8'h3C);
    compare_all("wr_rd");

    // Two writes in the same bank and row
    send(1'b1, 20'h0_8040, 8'hA1, 1'b1);
    send(1'b1, 20'h0_8048, 8'h5E, 1'b1);
    wait_quiet();
    compare_all("same_row");

    // Randomized batches with varying acknowledge latency
    for (int b = 0; b < 8; b++) begin
      ack_extra = $urandom_range(0, 3);
      nreq = $urandom_range(1, 6);
      for (int i = 0; i < nreq; i++) begin
        a  = {4'($urandom), 3'($urandom), 7'($urandom_range(0, 3)), 3'($urandom), 3'($urandom)};
        if (a == l2_req_instr) a = a ^ 20'h1;
        rw = 1'($urandom);
        send(rw, a, 8'($urandom), 1'b1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_quiet();
      compare_all("rand");
    end

    // Burst of incrementing addresses while the first command is stalled
    ack_extra = 0;
    hold_ack  = 1;
    for (int i = 0; i < 128; i++) begin
      a = 20'h0_4000 + AW'(i);
      send(1'b1, a, 8'(i) ^ 8'h5A, i < FIFO_DEPTH + 1);
    end
    repeat (5) @(negedge clk);
    hold_ack = 0;
    wait_quiet();
    compare_all("burst");

    send(1'b0, 20'h0_4003, 8'h00, 1'b1);
    send(1'b0, 20'h0_4008, 8'h00, 1'b1);
    send(1'b0, 20'h0_4010, 8'h00, 1'b1);
    wait_quiet();
    compare_all("burst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dram_controller.md
# dram_controller

Single-channel DRAM controller between the L2 cache and a bit-serial DRAM bank model. It captures L2 read/write requests into an input FIFO and translates each request address into bank/row/column. Each request is serviced with a precharge/activate/read-or-write command sequence over a 4-phase req/ack handshake. Data moves one bit per cycle on a single-bit DRAM data pin, and read bytes are returned to L2.

## Interface
Parameters:
- L2_REQ_WIDTH, 20: L2 request address width.
- DATA_WIDTH, 8: L2 data width, equal to the bits transferred per access.
- NUM_OF_BANKS, 8: number of banks; bank_sel width.
- NUM_OF_ROWS, 128: rows per bank; row_sel width.
- NUM_OF_COLS, 8: columns per row; col_sel width.
- CONCAT_ADDRESS, 20: width of the stored address field in the FIFO (≤ L2_REQ_WIDTH).

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock.
- rst_b  in  1  synchronous active-low reset.
- l2_rw_req  in  1  request type: 1 write, 0 read.
- l2_req_instr  in  L2_REQ_WIDTH  request address.
- l2_req_data  in  DATA_WIDTH  write data.
- l2_rsp_data  out  DATA_WIDTH  last completed read byte.
- cmd_req  out  1  command request to the DRAM model.
- cmd_ack  in  1  command acknowledge.
- cmd  out  2  command: 00 PRECHARGE, 01 ACTIVATE, 10 WRITE, 11 READ.
- bank_sel  out  NUM_OF_BANKS  one-hot bank select.
- row_sel  out  NUM_OF_ROWS  one-hot row select.
- col_sel  out  NUM_OF_COLS  one-hot column select.
- bank_rw  out  1  array direction: 1 write, 0 read.
- buf_rw  out  1  row-buffer direction: 1 load from pin, 0 drive to pin.
- dram_data  inout  1  serial data; the controller drives it only during write transfer, and it is high-Z otherwise.

Internal binary indices bank_id, row_id and col_id are also exported as hierarchical nets for the DRAM model.

## Operation
- **Enqueue.** A request is pushed into the 8-entry FIFO (l2_req_buffer) on any cycle where l2_req_instr differs from its value registered on the previous cycle. The entry holds {l2_rw_req, l2_req_instr[CONCAT_ADDRESS-1:0], l2_req_data}.
- **FIFO full.** A push while full is dropped. Pop happens only when the FSM is in IDLE and the FIFO is non-empty.
- **Address translation.** offset = addr[2:0] (byte offset, not used for transfer). col_id = addr[5:3]. row_id = addr[12:6]. bank_id = addr[15:13]. addr[19:16] are ignored. Field widths are $clog2 of the matching parameter. Each *_sel output is the one-hot decode of its *_id.
- **FSM states.**
  - IDLE: on pop, go to PRE.
  - PRE: issue PRECHARGE, then go to ACT.
  - ACT: issue ACTIVATE, then go to RW.
  - RW: issue WRITE or READ, then go to XFER.
  - XFER: access_count is loaded with DATA_WIDTH and decrements once per cycle. Bit access_count-1 down to 0 moves each cycle, MSB first.
    - Write: the controller drives the data bit and sets bank_rw=1, buf_rw=1.
    - Read: the controller samples dram_data, shifting in MSB first, with bank_rw=0, buf_rw=0.
  - When access_count reaches 0, go to IDLE. A read then updates l2_rsp_data on that cycle.
- **Command handshake (4-phase).**
  - Assert cmd_req with cmd, sels and bank_rw stable.
  - Wait for cmd_ack=1, then deassert cmd_req.
  - Wait for cmd_ack=0 before the next command.
  - cmd_ack has no timeout.

## Timing
- **Reset values.** All outputs 0, dram_data high-Z, FSM in IDLE, FIFO empty, access_count 0. Reset mid-operation aborts the current access immediately; the queue is lost.
- **Push and pop.** A push is visible to pop on the cycle after it is written. IDLE→PRE takes 1 cycle after pop.
- **Handshake response.** cmd_req falls the cycle after cmd_ack is sampled high. The next command is issued the cycle after cmd_ack is sampled low.
- **Transfer.** XFER lasts exactly DATA_WIDTH cycles.
- **Simultaneous push and pop.** Both are allowed, and the count is unchanged.

## Configuration
- DRAM_CTRL_ROW_HIT_EN defined (open-page policy):
  - The controller tracks the open row per bank.
  - If the popped request hits the open row of its bank, PRE and ACT are skipped (IDLE→RW).
  - On a miss, PRE is issued first.
- Undefined (closed-page policy): every request runs PRE→ACT→RW→XFER.

## Test plan
- Reset: hold rst_b=0 for 2 cycles → all outputs 0, cmd_req=0, FIFO empty.
- Single write to 20'h0_A5C8 with data 8'h3C → command sequence PRECHARGE, ACTIVATE, WRITE with bank_sel=8'b0010_0000 (bank 5), one-hot row 23, col_sel=8'b0000_0010, then 8 XFER cycles driving 0,0,1,1,1,1,0,0.
- Write then read of the same address (8'h3C) → l2_rsp_data=8'h3C after the read XFER.
- Ack delay: cmd_ack 8 ns after cmd_req edges (clk period 10 ns) → cmd_req is held high until ack, with no command overlap.
- 128 sequential incrementing addresses at one per cycle → 8 are accepted while busy and the excess is dropped with no FIFO overflow corruption. access_count returns to 0 after the last accepted request.
- With DRAM_CTRL_ROW_HIT_EN: two writes to the same bank and row → the second issues only WRITE.
